uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte/valid/ready plus error pulses.
// The receiver uses the master modport; the consumer uses the slave modport.
interface uart_rx_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  modport master (input rx_ready, output rx_data, output rx_valid, output frame_err, output overrun);
  modport slave  (output rx_ready, input rx_data, input rx_valid, input frame_err, input overrun);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ready output, framing-error
// and overrun pulses, and a BREAK state that waits out a line held low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic rx_in,
  output logic busy,
  uart_rx_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [12:0] BIT_END  = 13'(CLKS_PER_BIT - 1);
  localparam logic [12:0] HALF_END = 13'(HALF_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic        meta_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q;
  logic        load_s, ferr_s;

  // Two-flop synchronizer; idle-high reset so reset never looks like a start bit.
  always_ff @(posedge clk_50M) begin
    if (!rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      rx_s_q <= meta_q;
    end
  end

  // Frame sequencing: half-bit start qualification, then full-bit sample spacing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load_s    = 1'b0;
    ferr_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = 13'd0;
        end else begin
          cnt_d   = 13'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d     = 13'd0;
          bit_idx_d = 3'd0;
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d            = 13'd0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = 13'd0;
          if (rx_s_q) begin
            load_s  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 13'd0;
      end
    endcase
  end

  // Output handshake: a load coinciding with a consume is not an overrun.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = ferr_s;
    if (load_s) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !bus.rx_ready;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_50M) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 13'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx at a short bit period, comparing
// against a byte-level reference model of the valid/ready/overrun rules.
module tb_uart_rx;

  localparam int CPB  = 32;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic clk_50M = 1'b0;
  logic rst     = 1'b0;
  logic rx_in   = 1'b1;
  logic busy;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .rx_in   (rx_in),
    .busy    (busy),
    .bus     (bus.master)
  );

  always #10 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0;
  int ovr_cnt = 0, ferr_cnt = 0, vrise_cnt = 0;
  logic prev_valid = 1'b0;

  // Reference model state: the byte a consumer should see and pending overruns.
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  int         m_ovr = 0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.rx_valid && !prev_valid) begin
      vrise_cnt <= vrise_cnt + 1;
      rise_cyc  <= cyc;
    end
    prev_valid <= bus.rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  // Model a good frame landing; the model consumer never acks during a frame.
  task automatic model_load(input logic [7:0] d);
    if (m_valid) m_ovr++;
    m_valid = 1'b1;
    m_data  = d;
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, v0, f0, o0;
    logic [7:0] d, a, b;
    bus.rx_ready = 1'b0;

    // Reset values
    tick(3);
    chk("rst_data",  bus.rx_data, 8'h00);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_ferr",  bus.frame_err, 1'b0);
    chk("rst_ovr",   bus.overrun, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    rst = 1'b1;
    tick(4);

    // 0x55 with latency measurement, then one-cycle consume
    send_frame(8'h55, 1'b1);
    model_load(8'h55);
    lat = rise_cyc - start_cyc;
    chk("latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
    chk("x55_data",  bus.rx_data, m_data);
    chk("x55_valid", bus.rx_valid, 1'b1);
    consume();
    chk("x55_consumed", bus.rx_valid, 1'b0);
    bus.rx_ready = 1'b1;
    tick(3);
    bus.rx_ready = 1'b0;
    chk("ready_idle_noeffect", bus.rx_valid, 1'b0);

    // Back-to-back 0xA3, 0x3C with no consumer
    o0 = ovr_cnt;
    send_frame(8'hA3, 1'b1);
    model_load(8'hA3);
    send_frame(8'h3C, 1'b1);
    model_load(8'h3C);
    chk("b2b_ovr",   ovr_cnt - o0, 1);
    chk("b2b_data",  bus.rx_data, 8'h3C);
    chk("b2b_valid", bus.rx_valid, 1'b1);
    consume();

    // Short low glitch is rejected in START
    v0 = vrise_cnt; f0 = ferr_cnt;
    rx_in = 1'b0;
    tick(4);
    chk("glitch_busy", busy, 1'b1);
    tick(6);
    rx_in = 1'b1;
    tick(HALF + 4);
    chk("glitch_idle",  busy, 1'b0);
    chk("glitch_novld", vrise_cnt - v0, 0);
    chk("glitch_noerr", ferr_cnt - f0, 0);

    // Stop bit low, line held low: one frame_err, stays busy until line high
    send_frame(8'h11, 1'b1);
    model_load(8'h11);
    v0 = vrise_cnt; f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    tick(20 * CPB);
    chk("brk_ferr_once", ferr_cnt - f0, 1);
    chk("brk_busy",      busy, 1'b1);
    chk("brk_data_kept", bus.rx_data, m_data);
    chk("brk_vld_kept",  bus.rx_valid, m_valid);
    chk("brk_novld",     vrise_cnt - v0, 0);
    rx_in = 1'b1;
    tick(4);
    chk("brk_released", busy, 1'b0);
    consume();
    send_frame(8'h12, 1'b1);
    model_load(8'h12);
    chk("after_brk_data", bus.rx_data, 8'h12);
    consume();

    // Reset during data bit 4 of 0x81
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_in = d[4];
    tick(HALF);
    rst = 1'b0;
    rx_in = 1'b1;
    tick(2);
    m_valid = 1'b0; m_data = 8'h00;
    chk("mid_rst_data",  bus.rx_data, 8'h00);
    chk("mid_rst_valid", bus.rx_valid, 1'b0);
    chk("mid_rst_busy",  busy, 1'b0);
    chk("mid_rst_ferr",  bus.frame_err, 1'b0);
    chk("mid_rst_ovr",   bus.overrun, 1'b0);
    rst = 1'b1;
    v0 = vrise_cnt; f0 = ferr_cnt;
    tick(12 * CPB);
    chk("mid_rst_novld", vrise_cnt - v0, 0);
    chk("mid_rst_noerr", ferr_cnt - f0, 0);
    send_frame(8'h7E, 1'b1);
    model_load(8'h7E);
    chk("after_rst_data", bus.rx_data, 8'h7E);

    // Consume exactly on the load of a second byte: no overrun
    a = 8'hC5; b = 8'h2B;
    consume();
    send_frame(a, 1'b1);
    model_load(a);
    o0 = ovr_cnt;
    fork
      send_frame(b, 1'b1);
      begin
        tick(LAT);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        chk("coinc_valid", bus.rx_valid, 1'b1);
        chk("coinc_data",  bus.rx_data, b);
      end
    join
    m_valid = 1'b1; m_data = b;
    tick(2);
    chk("coinc_no_ovr", ovr_cnt - o0, 0);
    consume();

    // Randomized frames, gaps and consumer behaviour against the model
    o0 = ovr_cnt; m_ovr = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      tick($urandom_range(0, 5));
      send_frame(d, 1'b1);
      model_load(d);
      chk("rnd_data",  bus.rx_data, m_data);
      chk("rnd_valid", bus.rx_valid, 1'b1);
      chk("rnd_ovr",   ovr_cnt - o0, m_ovr);
      if ($urandom_range(0, 1) == 1) begin
        consume();
        chk("rnd_consumed", bus.rx_valid, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
